// File: rtl/layer_serializer_if.sv
// Handshake bundle for layer_serializer: vector capture side and word stream side.
interface layer_serializer_if #(
  parameter int NN = 30,
  parameter int DW = 16
) ();
  logic             in_valid;
  logic [NN*DW-1:0] in_data;
  logic             in_mode;
  logic             in_ready;
  logic [DW-1:0]    out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  // Producer of vectors / consumer of words (the surrounding datapath or bench)
  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  // The serializer itself
  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/layer_serializer.sv
// Parallel-to-serial converter between fully-connected layers. A one-vector
// hold buffer decouples capture from streaming so consecutive vectors leave
// without a bubble; mode 1 replaces the stream by the argmax index.
module layer_serializer #(
  parameter int NN     = 30,
  parameter int DW     = 16,
  parameter int SIGNED = 1
) (
  input  logic               clk,
  input  logic               rst,
  layer_serializer_if.slave  bus,
  output logic               overflow,
  input  logic               clr_overflow
);

  localparam int            CW       = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NN - 1);

  typedef enum logic [1:0] {IDLE, STREAM, SCAN, RESULT} state_t;

  state_t           state_q, state_d;
  logic             hold_full_q, hold_full_d;
  logic             overflow_q, overflow_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [DW-1:0]    out_data_q, out_data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NN*DW-1:0] hold_q, hold_d;
  logic             hold_mode_q, hold_mode_d;
  logic [NN*DW-1:0] sh_q, sh_d;
  logic [DW-1:0]    best_q, best_d;
  logic [CW-1:0]    best_idx_q, best_idx_d;

  logic capture, drop, accept, vec_done, xfer, scan_done;

  // Word select from a packed vector; indices past the end read as zero.
  function automatic logic [DW-1:0] word_at(input logic [NN*DW-1:0] v, input int idx);
    word_at = '0;
    for (int i = 0; i < NN; i++) begin
      if (i == idx) word_at = v[i*DW +: DW];
    end
  endfunction

  // Strict greater-than so ties keep the lowest index.
  function automatic logic word_gt(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic signed [DW-1:0] sa;
    logic signed [DW-1:0] sb;
    sa = a;
    sb = b;
    if (SIGNED != 0) word_gt = (sa > sb);
    else             word_gt = (a > b);
  endfunction

  // Handshake events; the hold->shift transfer only ever sees the registered hold flag.
  always_comb begin
    capture   = bus.in_valid && !hold_full_q;
    drop      = bus.in_valid && hold_full_q;
    accept    = out_valid_q && bus.out_ready;
    vec_done  = (state_q == STREAM || state_q == RESULT) && accept && out_last_q;
    xfer      = hold_full_q && (state_q == IDLE || vec_done);
    scan_done = (NN == 1) || ((cnt_q + CW'(1)) == LAST_IDX);
  end

  // Hold buffer and sticky overflow (a drop beats a simultaneous clear).
  always_comb begin
    hold_full_d = hold_full_q;
    if (capture)   hold_full_d = 1'b1;
    else if (xfer) hold_full_d = 1'b0;
    overflow_d = overflow_q;
    if (drop)              overflow_d = 1'b1;
    else if (clr_overflow) overflow_d = 1'b0;
    hold_d      = capture ? bus.in_data : hold_q;
    hold_mode_d = capture ? bus.in_mode : hold_mode_q;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (xfer)                            state_d = hold_mode_q ? SCAN : STREAM;
    else if (vec_done)                   state_d = IDLE;
    else if (state_q == SCAN && scan_done) state_d = RESULT;
  end

  // Output word, counter, shift register and argmax tracking.
  always_comb begin
    int            scan_idx;
    logic [DW-1:0] scan_word;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    scan_idx    = int'(cnt_q) + 1;
    scan_word   = word_at(sh_q, scan_idx);
    if (xfer) begin
      sh_d  = hold_q;
      cnt_d = '0;
      if (hold_mode_q) begin
        best_d      = hold_q[DW-1:0];
        best_idx_d  = '0;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end else begin
        out_data_d  = hold_q[DW-1:0];
        out_valid_d = 1'b1;
        out_last_d  = (NN == 1);
      end
    end else if (vec_done) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else if (state_q == STREAM && accept) begin
      cnt_d      = cnt_q + CW'(1);
      out_data_d = scan_word;
      out_last_d = ((cnt_q + CW'(1)) == LAST_IDX);
    end else if (state_q == SCAN) begin
      if (NN > 1 && word_gt(scan_word, best_q)) begin
        best_d     = scan_word;
        best_idx_d = CW'(scan_idx);
      end
      cnt_d = cnt_q + CW'(1);
      if (scan_done) begin
        out_data_d  = DW'(best_idx_d);
        out_valid_d = 1'b1;
        out_last_d  = 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Control and output registers; reset discards any vector in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_full_q <= 1'b0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      cnt_q       <= '0;
    end else begin
      hold_full_q <= hold_full_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      cnt_q       <= cnt_d;
    end
  end

  // Vector storage; contents are only read when the matching flag/state says valid.
  always_ff @(posedge clk) begin
    hold_q      <= hold_d;
    hold_mode_q <= hold_mode_d;
    sh_q        <= sh_d;
    best_q      <= best_d;
    best_idx_q  <= best_idx_d;
  end

  assign bus.in_ready  = ~hold_full_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign overflow      = overflow_q;

endmodule
